hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_md_sequencer.sv | 75 +++++++
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Purpose: shared definitions for the pipeline hazard controller. It holds
//          the MD (multiply/divide) sequencer state encoding and the default
//          busy-cycle counts for mult/multu and div/divu.
// Ports:   none (package).
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;  // must fit the 4-bit MD counter (<= 15)

  localparam int MD_CNT_W = 4;

  // Busy-cycle count for an MD launch, truncated to the counter width.
  function automatic logic [MD_CNT_W-1:0] md_load_value(input logic is_div,
                                                        input int   mult_cycles,
                                                        input int   div_cycles);
    return is_div ? MD_CNT_W'(div_cycles) : MD_CNT_W'(mult_cycles);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_sequencer.sv
// md_sequencer
// Purpose: tracks the latency of the multi-cycle multiply/divide unit.
//          A launch moves IDLE/DONE -> BUSY and loads a down-counter with
//          the operation latency. BUSY lasts exactly that many cycles, then
//          DONE is held for one cycle to mark the result valid.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset; aborts any operation
//   start    in   E-stage instruction launches mult/div this cycle
//   is_div   in   qualifies start: 1 = div, 0 = mult
//   md_busy  out  MD unit computing (state BUSY)
//   md_done  out  one-cycle result-valid pulse (state DONE)
module md_sequencer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  md_state_t             state_reg, state_next;
  logic [MD_CNT_W-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      // DONE accepts a new launch directly so back-to-back ops lose no cycle.
      MD_IDLE, MD_DONE: begin
        if (start) begin
          state_next = MD_BUSY;
          cnt_next   = md_load_value(is_div, MULT_CYCLES, DIV_CYCLES);
        end else begin
          state_next = MD_IDLE;
        end
      end
      // A launch while busy is dropped; the pipeline should never issue one.
      MD_BUSY: begin
        cnt_next = cnt_reg - MD_CNT_W'(1);
        if (cnt_reg == MD_CNT_W'(1)) begin
          state_next = MD_DONE;
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Decoded from state so reset clears both outputs without waiting for clk.
  assign md_busy = (state_reg == MD_BUSY);
  assign md_done = (state_reg == MD_DONE);

  md_start_while_busy : assert property (
    @(posedge clk) disable iff (!reset) !(start && state_reg == MD_BUSY)
  ) else $error("md_sequencer: MD launch while unit busy is ignored");

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Purpose: stall/flush/freeze control for a 5-stage pipeline using
//          Tuse/Tnew hazard detection, plus MD-unit interlocking.
// Ports:
//   clk                    in   clock, rising edge
//   reset                  in   asynchronous active-low reset
//   d_rs_addr, d_rt_addr   in   D-stage source registers
//   d_tuse_rs, d_tuse_rt   in   cycles until D-stage needs rs/rt
//   d_is_md                in   D-stage instruction uses the MD unit
//   e_reg_addr, m_reg_addr in   E/M destination register (0 = none)
//   e_tnew, m_tnew         in   cycles until E/M result is ready
//   e_md_start             in   E-stage launches mult/div this cycle
//   e_md_div               in   qualifies e_md_start: 1 = div, 0 = mult
//   mem_wait               in   data memory not ready: freeze everything
//   pc_en, fd_en, de_en,
//   em_en, mw_en           out  PC and pipeline register enables
//   de_flush               out  insert a bubble into ID/EX
//   md_busy, md_done       out  MD unit status
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_is_md,
  input  logic [4:0] e_reg_addr,
  input  logic [4:0] m_reg_addr,
  input  logic [1:0] e_tnew,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_div,
  input  logic       mem_wait,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_en,
  output logic       em_en,
  output logic       mw_en,
  output logic       de_flush,
  output logic       md_busy,
  output logic       md_done
);

  // Producer stages: index 0 = E, index 1 = M.
  logic [4:0] prod_addr [2];
  logic [1:0] prod_tnew [2];
  logic [1:0] prod_hit;
  logic       stall_data;
  logic       stall_md;
  logic       stall;

  assign prod_addr[0] = e_reg_addr;
  assign prod_addr[1] = m_reg_addr;
  assign prod_tnew[0] = e_tnew;
  assign prod_tnew[1] = m_tnew;

  // A consumer must wait when it needs the value sooner than the producer
  // can supply it. $0 is hard-wired, so it never creates a dependency.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_prod
      assign prod_hit[gi] = (prod_addr[gi] != 5'd0) &&
                            (((prod_addr[gi] == d_rs_addr) && (d_tuse_rs < prod_tnew[gi])) ||
                             ((prod_addr[gi] == d_rt_addr) && (d_tuse_rt < prod_tnew[gi])));
    end
  endgenerate

  assign stall_data = |prod_hit;
  // An MD instruction in D must wait for the unit, including one being
  // launched from E this very cycle.
  assign stall_md   = d_is_md && (md_busy || e_md_start);
  assign stall      = stall_data || stall_md;

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_en    = 1'b1;
    em_en    = 1'b1;
    mw_en    = 1'b1;
    de_flush = 1'b0;
    if (mem_wait) begin
      // Memory freeze overrides any stall: nothing moves, nothing is flushed.
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else if (stall) begin
      // Hold PC and IF/ID; later stages drain while a bubble enters EX.
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
  end

  // The MD unit keeps computing through memory freezes.
  md_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_sequencer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_div),
    .md_busy(md_busy),
    .md_done(md_done)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs_addr, d_rt_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt;
  logic       d_is_md;
  logic [4:0] e_reg_addr, m_reg_addr;
  logic [1:0] e_tnew, m_tnew;
  logic       e_md_start, e_md_div, mem_wait;
  logic       pc_en, fd_en, de_en, em_en, mw_en, de_flush, md_busy, md_done;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs_addr (d_rs_addr),
    .d_rt_addr (d_rt_addr),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_is_md   (d_is_md),
    .e_reg_addr(e_reg_addr),
    .m_reg_addr(m_reg_addr),
    .e_tnew    (e_tnew),
    .m_tnew    (m_tnew),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .mem_wait  (mem_wait),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .de_en     (de_en),
    .em_en     (em_en),
    .mw_en     (mw_en),
    .de_flush  (de_flush),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable bundle order: {pc_en, fd_en, de_en, em_en, mw_en, de_flush}
  localparam logic [5:0] EN_RUN    = 6'b111110;
  localparam logic [5:0] EN_STALL  = 6'b001111;
  localparam logic [5:0] EN_FREEZE = 6'b000000;

  function automatic logic [5:0] en_bus();
    return {pc_en, fd_en, de_en, em_en, mw_en, de_flush};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end else begin
      $display("ok   %s value=%b", name, act);
    end
  endtask

  task automatic idle_inputs();
    d_rs_addr = 0; d_rt_addr = 0; d_tuse_rs = 0; d_tuse_rt = 0; d_is_md = 0;
    e_reg_addr = 0; m_reg_addr = 0; e_tnew = 0; m_tnew = 0;
    e_md_start = 0; e_md_div = 0; mem_wait = 0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] e_addr;
    logic [1:0] e_tn;
    logic [4:0] m_addr;
    logic [1:0] m_tn;
    logic       mw;
    logic [5:0] exp_en;
  } vec_t;

  vec_t vecs [12];

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    chk("reset_busy", {7'd0, md_busy}, 8'd0);
    chk("reset_done", {7'd0, md_done}, 8'd0);
    chk("reset_en",   {2'd0, en_bus()}, {2'd0, EN_RUN});
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    //          name           rs  rt  tr tt  ea en  ma mn  mw  exp
    vecs[0]  = '{"idle",        0,  0, 0, 0,  0, 0,  0, 0, 0, EN_RUN};
    vecs[1]  = '{"load_use",    8,  0, 1, 0,  8, 2,  0, 0, 0, EN_STALL};
    vecs[2]  = '{"zero_reg",    0,  0, 0, 0,  0, 2,  0, 0, 0, EN_RUN};
    vecs[3]  = '{"tuse_eq",     8,  0, 2, 0,  8, 2,  0, 0, 0, EN_RUN};
    vecs[4]  = '{"m_rt_haz",    0,  9, 0, 0,  0, 0,  9, 1, 0, EN_STALL};
    vecs[5]  = '{"m_rt_ok",     0,  9, 0, 1,  0, 0,  9, 1, 0, EN_RUN};
    vecs[6]  = '{"no_match",    6,  7, 0, 0,  5, 3,  0, 0, 0, EN_RUN};
    vecs[7]  = '{"haz_memw",    8,  0, 1, 0,  8, 2,  0, 0, 1, EN_FREEZE};
    vecs[8]  = '{"idle_memw",   0,  0, 0, 0,  0, 0,  0, 0, 1, EN_FREEZE};
    vecs[9]  = '{"m_zero",      0,  0, 0, 0,  0, 0,  0, 3, 0, EN_RUN};
    vecs[10] = '{"e_rt31",      0, 31, 0, 2, 31, 3,  0, 0, 0, EN_STALL};
    vecs[11] = '{"both_stage",  4,  5, 1, 1,  4, 1,  5, 2, 0, EN_STALL};

    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      d_rs_addr = vecs[i].rs;      d_rt_addr = vecs[i].rt;
      d_tuse_rs = vecs[i].tuse_rs; d_tuse_rt = vecs[i].tuse_rt;
      e_reg_addr = vecs[i].e_addr; e_tnew = vecs[i].e_tn;
      m_reg_addr = vecs[i].m_addr; m_tnew = vecs[i].m_tn;
      mem_wait = vecs[i].mw;
      #1;
      chk(vecs[i].name, {2'd0, en_bus()}, {2'd0, vecs[i].exp_en});
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    // Mult: start at cycle 0 -> busy 1..5, done 6.
    for (int c = 0; c <= 8; c++) begin
      idle_inputs();
      e_md_start = (c == 0);
      #1;
      chk($sformatf("mult_busy_c%0d", c), {7'd0, md_busy}, {7'd0, (c >= 1 && c <= 5)});
      chk($sformatf("mult_done_c%0d", c), {7'd0, md_done}, {7'd0, (c == 6)});
      @(negedge clk);
    end

    // Div with a D-stage MD instruction waiting from cycle 3, then a mult
    // launched from DONE at cycle 11.
    for (int c = 0; c <= 18; c++) begin
      idle_inputs();
      e_md_start = (c == 0) || (c == 11);
      e_md_div   = (c == 0);
      d_is_md    = (c >= 3 && c <= 10);
      #1;
      chk($sformatf("div_busy_c%0d", c), {7'd0, md_busy},
          {7'd0, (c >= 1 && c <= 10) || (c >= 12 && c <= 16)});
      chk($sformatf("div_done_c%0d", c), {7'd0, md_done}, {7'd0, (c == 11) || (c == 17)});
      chk($sformatf("div_en_c%0d", c), {2'd0, en_bus()},
          {2'd0, (c >= 3 && c <= 10) ? EN_STALL : EN_RUN});
      @(negedge clk);
    end

    // Memory freeze over a pending hazard while a mult keeps counting.
    for (int c = 0; c <= 7; c++) begin
      idle_inputs();
      e_reg_addr = 8; e_tnew = 2; d_rs_addr = 8; d_tuse_rs = 1;
      e_md_start = (c == 0);
      mem_wait   = (c >= 2 && c <= 4);
      #1;
      chk($sformatf("memw_en_c%0d", c), {2'd0, en_bus()},
          {2'd0, (c >= 2 && c <= 4) ? EN_FREEZE : EN_STALL});
      chk($sformatf("memw_busy_c%0d", c), {7'd0, md_busy}, {7'd0, (c >= 1 && c <= 5)});
      chk($sformatf("memw_done_c%0d", c), {7'd0, md_done}, {7'd0, (c == 6)});
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    // Reset aborts a div at cycle 3 with no later done pulse.
    for (int c = 0; c <= 3; c++) begin
      idle_inputs();
      e_md_start = (c == 0);
      e_md_div   = 1'b1;
      #1;
      if (c == 3) chk("rst_pre_busy", {7'd0, md_busy}, 8'd1);
      if (c < 3) @(negedge clk);
    end
    #1;
    reset = 1'b0;
    #1;
    chk("rst_abort_busy", {7'd0, md_busy}, 8'd0);
    chk("rst_abort_done", {7'd0, md_done}, 8'd0);
    chk("rst_abort_en",   {2'd0, en_bus()}, {2'd0, EN_RUN});
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      chk($sformatf("post_rst_c%0d", c), {6'd0, md_busy, md_done}, 8'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
